// File: rtl/riscv_dift_tag_regfile_pkg.sv
// Shared DIFT tag types and scrub FSM state encoding for the tag register file.
package riscv_dift_tag_regfile_pkg;

   localparam int DIFT_TAG_SIZE = 4;

   typedef logic [DIFT_TAG_SIZE-1:0] dift_tag_t;

   typedef enum logic [1:0] {
      DIFT_SCRUB_IDLE = 2'd0,
      DIFT_SCRUB_RUN  = 2'd1,
      DIFT_SCRUB_DONE = 2'd2
   } dift_scrub_state_e;

endpackage

// File: rtl/riscv_dift_tag_scrub_fsm.sv
// Bulk tag-scrub sequencer: walks entries 1..2**ADDR_WIDTH-1 issuing one clear strobe per cycle,
// then holds a one-cycle DONE state before returning to idle.
module riscv_dift_tag_scrub_fsm
   import riscv_dift_tag_regfile_pkg::*;
#(
   parameter int ADDR_WIDTH = 5
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  scrub_req_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic                  clr_en_o,
   output logic [ADDR_WIDTH-1:0] clr_idx_o
);

   localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = '1;
   localparam logic [ADDR_WIDTH-1:0] FIRST_IDX = ADDR_WIDTH'(1);

   dift_scrub_state_e     state_q;
   logic [ADDR_WIDTH-1:0] cnt_q;
   logic                  busy_q;
   logic                  done_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= DIFT_SCRUB_IDLE;
         cnt_q   <= FIRST_IDX;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            DIFT_SCRUB_IDLE: begin
               done_q <= 1'b0;
               if (scrub_req_i) begin
                  state_q <= DIFT_SCRUB_RUN;
                  cnt_q   <= FIRST_IDX;
                  busy_q  <= 1'b1;
               end
            end
            DIFT_SCRUB_RUN: begin
               // Exit at the last index so the counter never wraps back through x0.
               if (cnt_q == LAST_IDX) begin
                  state_q <= DIFT_SCRUB_DONE;
                  done_q  <= 1'b1;
               end else begin
                  cnt_q <= cnt_q + FIRST_IDX;
               end
            end
            DIFT_SCRUB_DONE: begin
               done_q <= 1'b0;
               if (scrub_req_i) begin
                  state_q <= DIFT_SCRUB_RUN;
                  cnt_q   <= FIRST_IDX;
               end else begin
                  state_q <= DIFT_SCRUB_IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= DIFT_SCRUB_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   assign busy_o    = busy_q;
   assign done_o    = done_q;
   assign clr_en_o  = (state_q == DIFT_SCRUB_RUN);
   assign clr_idx_o = cnt_q;

endmodule

// File: rtl/riscv_dift_tag_regfile.sv
// DIFT tag register file: three combinational read ports, EX and LSU write ports, bulk scrub.
// Define DIFT_TAGRF_BYPASS_EN to forward same-cycle writes/scrub clears to the read ports.
module riscv_dift_tag_regfile
   import riscv_dift_tag_regfile_pkg::*;
#(
   parameter int ADDR_WIDTH = 5,
   parameter int TAG_WIDTH  = DIFT_TAG_SIZE
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] raddr_a_i,
   output logic [TAG_WIDTH-1:0]  rtag_a_o,
   input  logic [ADDR_WIDTH-1:0] raddr_b_i,
   output logic [TAG_WIDTH-1:0]  rtag_b_o,
   input  logic [ADDR_WIDTH-1:0] raddr_c_i,
   output logic [TAG_WIDTH-1:0]  rtag_c_o,
   input  logic                  we_lsu_i,
   input  logic [ADDR_WIDTH-1:0] waddr_lsu_i,
   input  logic [TAG_WIDTH-1:0]  wtag_lsu_i,
   input  logic                  we_ex_i,
   input  logic [ADDR_WIDTH-1:0] waddr_ex_i,
   input  logic [TAG_WIDTH-1:0]  wtag_ex_i,
   input  logic                  scrub_req_i,
   output logic                  scrub_busy_o,
   output logic                  scrub_done_o
);

   localparam int NUM_REGS = 2 ** ADDR_WIDTH;

   logic [TAG_WIDTH-1:0]  mem_q [NUM_REGS];
   logic                  clr_en;
   logic [ADDR_WIDTH-1:0] clr_idx;
   logic [ADDR_WIDTH-1:0] raddr [3];
   logic [TAG_WIDTH-1:0]  rtag  [3];

   riscv_dift_tag_scrub_fsm #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_scrub (
      .clk         (clk),
      .rst         (rst),
      .scrub_req_i (scrub_req_i),
      .busy_o      (scrub_busy_o),
      .done_o      (scrub_done_o),
      .clr_en_o    (clr_en),
      .clr_idx_o   (clr_idx)
   );

   // Entry 0 is held at its reset value and never written; port writes beat a same-cycle scrub.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         for (int i = 1; i < NUM_REGS; i++) begin
            if (we_ex_i && (waddr_ex_i == ADDR_WIDTH'(i))) begin
               mem_q[i] <= wtag_ex_i;
            end else if (we_lsu_i && (waddr_lsu_i == ADDR_WIDTH'(i))) begin
               mem_q[i] <= wtag_lsu_i;
            end else if (clr_en && (clr_idx == ADDR_WIDTH'(i))) begin
               mem_q[i] <= '0;
            end
         end
      end
   end

   assign raddr[0] = raddr_a_i;
   assign raddr[1] = raddr_b_i;
   assign raddr[2] = raddr_c_i;

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_rport
         always_comb begin
            rtag[gi] = mem_q[raddr[gi]];
            if (raddr[gi] == '0) begin
               rtag[gi] = '0;
`ifdef DIFT_TAGRF_BYPASS_EN
            end else if (we_ex_i && (waddr_ex_i == raddr[gi])) begin
               rtag[gi] = wtag_ex_i;
            end else if (we_lsu_i && (waddr_lsu_i == raddr[gi])) begin
               rtag[gi] = wtag_lsu_i;
            end else if (clr_en && (clr_idx == raddr[gi])) begin
               rtag[gi] = '0;
`endif
            end
         end
      end
   endgenerate

   assign rtag_a_o = rtag[0];
   assign rtag_b_o = rtag[1];
   assign rtag_c_o = rtag[2];

endmodule

// File: tb/tb_riscv_dift_tag_regfile.sv
// Scoreboard bench for riscv_dift_tag_regfile: stimulus queues expected values per cycle,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_riscv_dift_tag_regfile;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [4:0] raddr_a_i = '0, raddr_b_i = '0, raddr_c_i = '0;
   logic [3:0] rtag_a_o, rtag_b_o, rtag_c_o;
   logic       we_lsu_i = 1'b0, we_ex_i = 1'b0;
   logic [4:0] waddr_lsu_i = '0, waddr_ex_i = '0;
   logic [3:0] wtag_lsu_i = '0, wtag_ex_i = '0;
   logic       scrub_req_i = 1'b0;
   logic       scrub_busy_o, scrub_done_o;

   riscv_dift_tag_regfile dut (
      .clk          (clk),
      .rst          (rst),
      .raddr_a_i    (raddr_a_i),
      .rtag_a_o     (rtag_a_o),
      .raddr_b_i    (raddr_b_i),
      .rtag_b_o     (rtag_b_o),
      .raddr_c_i    (raddr_c_i),
      .rtag_c_o     (rtag_c_o),
      .we_lsu_i     (we_lsu_i),
      .waddr_lsu_i  (waddr_lsu_i),
      .wtag_lsu_i   (wtag_lsu_i),
      .we_ex_i      (we_ex_i),
      .waddr_ex_i   (waddr_ex_i),
      .wtag_ex_i    (wtag_ex_i),
      .scrub_req_i  (scrub_req_i),
      .scrub_busy_o (scrub_busy_o),
      .scrub_done_o (scrub_done_o)
   );

   always #5 clk = ~clk;

   // sel: 0 = rtag_a, 1 = rtag_b, 2 = rtag_c, 3 = busy, 4 = done
   typedef struct {
      int         cyc;
      int         sel;
      logic [3:0] exp;
      string      name;
   } exp_t;

   exp_t q[$];
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic expect_out(input int sel, input logic [3:0] exp, input string name);
      exp_t e;
      e.cyc  = cyc;
      e.sel  = sel;
      e.exp  = exp;
      e.name = name;
      q.push_back(e);
   endtask

   always @(negedge clk) begin
      exp_t       e;
      logic [3:0] act;
      while (q.size() > 0 && q[0].cyc <= cyc) begin
         e = q.pop_front();
         checks++;
         if (e.cyc < cyc) begin
            errors++;
            $display("FAIL %s: check missed (queued cycle %0d, now %0d)", e.name, e.cyc, cyc);
         end else begin
            case (e.sel)
               0:       act = rtag_a_o;
               1:       act = rtag_b_o;
               2:       act = rtag_c_o;
               3:       act = {3'b000, scrub_busy_o};
               default: act = {3'b000, scrub_done_o};
            endcase
            if (act !== e.exp) begin
               errors++;
               $display("FAIL %s: cycle %0d got %h expected %h", e.name, cyc, act, e.exp);
            end else begin
               $display("ok   %s: cycle %0d value %h", e.name, cyc, act);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic ex_write(input logic [4:0] a, input logic [3:0] t);
      we_ex_i = 1'b1; waddr_ex_i = a; wtag_ex_i = t;
      step();
      we_ex_i = 1'b0;
   endtask

   // Pulse scrub_req, run the whole scrub checking busy/done each cycle; optional EX write at cnt wr_k.
   task automatic scrub_run(input int wr_k, input logic [4:0] wa, input logic [3:0] wt);
      scrub_req_i = 1'b1;
      step();
      scrub_req_i = 1'b0;
      for (int k = 1; k <= 32; k++) begin
         if (k == wr_k) begin
            we_ex_i = 1'b1; waddr_ex_i = wa; wtag_ex_i = wt;
         end
         expect_out(3, 4'd1, $sformatf("scrub_busy_k%0d", k));
         expect_out(4, (k == 32) ? 4'd1 : 4'd0, $sformatf("scrub_done_k%0d", k));
         step();
         we_ex_i = 1'b0;
      end
      expect_out(3, 4'd0, "scrub_busy_after");
      expect_out(4, 4'd0, "scrub_done_after");
   endtask

   initial begin
      // 1. reset
      step();
      rst = 1'b0;
      raddr_a_i = 5'd0; raddr_b_i = 5'd5; raddr_c_i = 5'd31;
      expect_out(0, 4'h0, "rst_x0");
      expect_out(1, 4'h0, "rst_x5");
      expect_out(2, 4'h0, "rst_x31");
      expect_out(3, 4'h0, "rst_busy");
      expect_out(4, 4'h0, "rst_done");
      step();

      // 2. basic write, x0 discard
      ex_write(5'd5, 4'hA);
      raddr_a_i = 5'd5;
      expect_out(0, 4'hA, "wr_x5");
      ex_write(5'd0, 4'hF);
      raddr_a_i = 5'd0;
      expect_out(0, 4'h0, "wr_x0");
      step();

      // 3. EX over LSU priority, then distinct addresses
      we_ex_i = 1'b1; waddr_ex_i = 5'd7; wtag_ex_i = 4'h3;
      we_lsu_i = 1'b1; waddr_lsu_i = 5'd7; wtag_lsu_i = 4'hC;
      step();
      waddr_lsu_i = 5'd8;
      step();
      we_ex_i = 1'b0; we_lsu_i = 1'b0;
      raddr_a_i = 5'd7; raddr_b_i = 5'd8;
      expect_out(0, 4'h3, "prio_x7");
      expect_out(1, 4'hC, "lsu_x8");
      step();

      // 4. preload all, full scrub, check all cleared
      for (int r = 1; r < 32; r++) ex_write(5'(r), 4'hF);
      raddr_b_i = 5'd2;
      scrub_req_i = 1'b1;
      step();
      scrub_req_i = 1'b0;
      expect_out(1, 4'hF, "scrub_x2_pending");
      for (int k = 1; k <= 32; k++) begin
         expect_out(3, 4'd1, $sformatf("busy_k%0d", k));
         expect_out(4, (k == 32) ? 4'd1 : 4'd0, $sformatf("done_k%0d", k));
         step();
      end
      expect_out(3, 4'd0, "busy_idle");
      expect_out(4, 4'd0, "done_idle");
      for (int r = 1; r < 32; r++) begin
         raddr_a_i = 5'(r);
         expect_out(0, 4'h0, $sformatf("scrubbed_x%0d", r));
         step();
      end

      // 5. port write vs scrub on the same entry
      scrub_run(3, 5'd3, 4'h5);
      raddr_a_i = 5'd3;
      expect_out(0, 4'h5, "scrub_wr_wins_x3");
      step();
      scrub_run(1, 5'd3, 4'h5);
      raddr_a_i = 5'd3;
      expect_out(0, 4'h0, "scrub_wr_early_x3");
      step();

      // 6. reset mid-scrub
      ex_write(5'd20, 4'hF);
      raddr_a_i = 5'd20;
      expect_out(0, 4'hF, "pre_rst_x20");
      scrub_req_i = 1'b1;
      step();
      scrub_req_i = 1'b0;
      for (int k = 1; k < 10; k++) step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      expect_out(3, 4'd0, "midrst_busy");
      expect_out(4, 4'd0, "midrst_done");
      expect_out(0, 4'h0, "midrst_x20");
      step();

`ifdef DIFT_TAGRF_BYPASS_EN
      we_ex_i = 1'b1; waddr_ex_i = 5'd9; wtag_ex_i = 4'h6;
      raddr_b_i = 5'd9;
      expect_out(1, 4'h6, "bypass_x9");
      step();
      we_ex_i = 1'b0;
`endif

      step();
      step();
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d checks never reached", q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
